// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer (TIMA/TMA/TAC).
package timer_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } tstate_t;

    localparam logic [1:0] TIMA_A = 2'd1;
    localparam logic [1:0] TMA_A  = 2'd2;
    localparam logic [1:0] TAC_A  = 2'd3;

    localparam int TAC_EN     = 2;
    localparam int TAC_SEL_HI = 1;
    localparam int TAC_SEL_LO = 0;

    // The bus presents inverted address bits; FF04 (offset 0) belongs to the divider.
    function automatic logic [1:0] bus_addr(input logic na1, input logic na0);
        return {~na1, ~na0};
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// CPU-side strobes and address decode for the FF04-FF07 register window.
interface timer_ctrl_if;
    logic ff04_ff07;
    logic tovy_na0;
    logic tola_na1;
    logic cpu_wr;
    logic cpu_rd;

    modport master (output ff04_ff07, tovy_na0, tola_na1, cpu_wr, cpu_rd);
    modport slave  (input  ff04_ff07, tovy_na0, tola_na1, cpu_wr, cpu_rd);
endinterface

// File: rtl/timer_tick_sel.sv
// Divider tap mux plus falling-edge detector; also reused by the APU frame sequencer.
module timer_tick_sel (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_en,
    input  logic [1:0] i_sel,
    input  logic [3:0] i_taps,
    output logic       o_inc
);
    logic w_sel;
    logic r_sel_q;

    // Gating with the enable before the edge detector means disabling on a high tap ticks once.
    assign w_sel = i_en & i_taps[i_sel];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_sel_q <= 1'b0;
        else         r_sel_q <= w_sel;
    end

    assign o_inc = r_sel_q & ~w_sel;
endmodule

// File: rtl/timer_ctrl.sv
// TIMA/TMA/TAC register file, bus tristate and the overflow/reload sequencer.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int         RELOAD_DELAY = 1,
    parameter logic [7:0] TAC_RD_MASK  = 8'hF8
) (
    input  logic          clk,
    input  logic          nreset,
    timer_ctrl_if.slave   bus,
    inout  wire  [7:0]    d,
    input  logic [3:0]    div_taps,
    output logic          int_timer,
    output logic [7:0]    tima_q
);
    tstate_t    r_state, w_state_nx;
    logic [7:0] r_tima, w_tima_nx;
    logic [7:0] r_tma;
    logic [2:0] r_tac;
    logic [1:0] r_cnt, w_cnt_nx;
    logic       r_int, w_int_nx;
    logic [1:0] w_a;
    logic       w_wr_tima, w_wr_tma, w_wr_tac, w_rd_en, w_inc;
    logic [7:0] w_rdata;

    assign w_a       = bus_addr(bus.tola_na1, bus.tovy_na0);
    assign w_wr_tima = bus.ff04_ff07 & bus.cpu_wr & (w_a == TIMA_A);
    assign w_wr_tma  = bus.ff04_ff07 & bus.cpu_wr & (w_a == TMA_A);
    assign w_wr_tac  = bus.ff04_ff07 & bus.cpu_wr & (w_a == TAC_A);
    assign w_rd_en   = bus.ff04_ff07 & bus.cpu_rd & (w_a != 2'd0);

    timer_tick_sel u_tick (
        .clk    (clk),
        .nreset (nreset),
        .i_en   (r_tac[TAC_EN]),
        .i_sel  (r_tac[TAC_SEL_HI:TAC_SEL_LO]),
        .i_taps (div_taps),
        .o_inc  (w_inc)
    );

    always_comb begin
        w_state_nx = r_state;
        w_tima_nx  = r_tima;
        w_cnt_nx   = r_cnt;
        w_int_nx   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_wr_tima) begin
                    w_tima_nx = d;
                end else if (w_inc) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nx  = 8'h00;
                        w_cnt_nx   = 2'(RELOAD_DELAY);
                        w_state_nx = OVF;
                    end else begin
                        w_tima_nx = r_tima + 8'd1;
                    end
                end
            end
            OVF: begin
                if (w_wr_tima) begin
                    w_tima_nx  = d;
                    w_cnt_nx   = 2'd0;
                    w_state_nx = RUN;
                end else if (r_cnt == 2'd1) begin
                    // A TMA write landing on the reload edge is forwarded straight into TIMA.
                    w_tima_nx  = w_wr_tma ? d : r_tma;
                    w_cnt_nx   = 2'd0;
                    w_int_nx   = 1'b1;
                    w_state_nx = RELOAD;
                end else begin
                    w_cnt_nx = r_cnt - 2'd1;
                    if (w_inc) w_tima_nx = r_tima + 8'd1;
                end
            end
            RELOAD: begin
                if (w_wr_tma) w_tima_nx = d;
                w_state_nx = RUN;
            end
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= RUN;
            r_tima  <= 8'h00;
            r_tma   <= 8'h00;
            r_tac   <= 3'b000;
            r_cnt   <= 2'd0;
            r_int   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tima  <= w_tima_nx;
            r_cnt   <= w_cnt_nx;
            r_int   <= w_int_nx;
            if (w_wr_tma) r_tma <= d;
            if (w_wr_tac) r_tac <= d[2:0];
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_a)
            TIMA_A:  w_rdata = r_tima;
            TMA_A:   w_rdata = r_tma;
            TAC_A:   w_rdata = TAC_RD_MASK | {5'b00000, r_tac};
            default: w_rdata = 8'h00;
        endcase
    end

    assign d         = w_rd_en ? w_rdata : 8'hzz;
    assign int_timer = r_int;
    assign tima_q    = r_tima;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_timer_ctrl;
    import timer_pkg::*;

    typedef struct {
        string      nm;
        bit         cd;
        logic [7:0] ed;
        bit         ct;
        logic [7:0] et;
        bit         ci;
        logic       ei;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [3:0] taps = 4'h0;
    wire  [7:0] d;
    logic       int_timer;
    logic [7:0] tima_q;
    logic [7:0] tb_d = 8'h00;
    logic       tb_den = 1'b0;
    logic       sample = 1'b0;
    logic       final_chk = 1'b0;
    logic       prev_int = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       q[$];
    exp_t       mon_e;

    timer_ctrl_if bus ();

    assign d = tb_den ? tb_d : 8'hzz;
    // Weak pull-down makes a released bus read as 0x00.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pd
        pulldown (d[gi]);
    end

    timer_ctrl #(.RELOAD_DELAY(1), .TAC_RD_MASK(8'hF8)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus.slave),
        .d         (d),
        .div_taps  (taps),
        .int_timer (int_timer),
        .tima_q    (tima_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (sample) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL queue_underflow: got sample with empty queue, required an entry");
            end else begin
                mon_e = q.pop_front();
                if (mon_e.cd) begin
                    n_cmp++;
                    if (d !== mon_e.ed) begin
                        n_bad++;
                        $display("FAIL %s: d=%02h required %02h", mon_e.nm, d, mon_e.ed);
                    end
                end
                if (mon_e.ct) begin
                    n_cmp++;
                    if (tima_q !== mon_e.et) begin
                        n_bad++;
                        $display("FAIL %s: tima_q=%02h required %02h", mon_e.nm, tima_q, mon_e.et);
                    end
                end
                if (mon_e.ci) begin
                    n_cmp++;
                    if (int_timer !== mon_e.ei) begin
                        n_bad++;
                        $display("FAIL %s: int_timer=%0b required %0b", mon_e.nm, int_timer, mon_e.ei);
                    end
                end
            end
        end
        if (prev_int) begin
            n_cmp++;
            if (int_timer !== 1'b0) begin
                n_bad++;
                $display("FAIL int_width: int_timer=%0b required 0 after a high cycle", int_timer);
            end
        end
        prev_int = int_timer;
        if (final_chk) begin
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL queue_drain: %0d entries left, required 0", q.size());
            end
        end
    end

    task automatic bus_set(input bit wr, input bit rd, input logic [1:0] a, input logic [7:0] wd);
        bus.ff04_ff07 = wr | rd;
        bus.cpu_wr    = wr;
        bus.cpu_rd    = rd;
        bus.tovy_na0  = ~a[0];
        bus.tola_na1  = ~a[1];
        tb_d          = wd;
        tb_den        = wr;
    endtask

    task automatic step();
        @(posedge clk); #1;
        bus_set(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic step_chk(input string nm, input bit cd, input logic [7:0] ed,
                            input bit ct, input logic [7:0] et, input bit ci, input logic ei);
        exp_t e;
        e.nm = nm; e.cd = cd; e.ed = ed; e.ct = ct; e.et = et; e.ci = ci; e.ei = ei;
        q.push_back(e);
        sample = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0;
        bus_set(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic ct(input string nm, input logic [7:0] et);
        step_chk(nm, 1'b0, 8'h00, 1'b1, et, 1'b0, 1'b0);
    endtask

    task automatic cti(input string nm, input logic [7:0] et, input logic ei);
        step_chk(nm, 1'b0, 8'h00, 1'b1, et, 1'b1, ei);
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [7:0] ed);
        bus_set(1'b0, 1'b1, a, 8'h00);
        step_chk(nm, 1'b1, ed, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        bus_set(1'b1, 1'b0, a, v);
        step();
    endtask

    // Loads TIMA=0xFF and produces one tap fall; returns at the start of the OVF cycle.
    task automatic to_ovf();
        wr(TIMA_A, 8'hFF);
        taps = 4'b0010; step();
        taps = 4'b0000; step();
    endtask

    initial begin
        bus_set(1'b0, 1'b0, 2'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        rd("rst_tima", TIMA_A, 8'h00);
        rd("rst_tma",  TMA_A,  8'h00);
        rd("rst_tac",  TAC_A,  8'hF8);
        bus_set(1'b0, 1'b0, TAC_A, 8'h00);
        bus.ff04_ff07 = 1'b1;
        step_chk("d_hiz", 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        rd("ff04_ignored", 2'd0, 8'h00);

        wr(TMA_A, 8'h80);
        wr(TAC_A, 8'h05);
        wr(TIMA_A, 8'hFE);
        taps = 4'b0010; ct("ovf_pre0", 8'hFE);
        taps = 4'b0000; ct("ovf_pre1", 8'hFE);
        taps = 4'b0010; ct("ovf_ff", 8'hFF);
        taps = 4'b0000; cti("ovf_ff2", 8'hFF, 1'b0);
        bus_set(1'b0, 1'b1, TIMA_A, 8'h00);
        step_chk("ovf_zero", 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cti("reload", 8'h80, 1'b1);
        cti("reload_done", 8'h80, 1'b0);

        to_ovf();
        bus_set(1'b1, 1'b0, TIMA_A, 8'h33); cti("cancel_ovf", 8'h00, 1'b0);
        cti("cancel_tima", 8'h33, 1'b0);
        cti("cancel_noint", 8'h33, 1'b0);

        to_ovf();
        ct("r_ovf", 8'h00);
        bus_set(1'b1, 1'b0, TIMA_A, 8'h11); cti("reload_wr_tima", 8'h80, 1'b1);
        cti("reload_tima_ign", 8'h80, 1'b0);

        to_ovf();
        ct("r2_ovf", 8'h00);
        bus_set(1'b1, 1'b0, TMA_A, 8'h44); cti("reload_wr_tma", 8'h80, 1'b1);
        cti("reload_tma_tima", 8'h44, 1'b0);
        rd("reload_tma_reg", TMA_A, 8'h44);

        to_ovf();
        bus_set(1'b1, 1'b0, TMA_A, 8'h55); cti("ovf_wr_tma", 8'h00, 1'b0);
        cti("ovf_tma_new", 8'h55, 1'b1);
        rd("ovf_tma_reg", TMA_A, 8'h55);
        ct("after_55", 8'h55);

        taps = 4'b0010; step();
        bus_set(1'b1, 1'b0, TAC_A, 8'h01); ct("dis_hi_wr", 8'h55);
        ct("dis_hi_pre", 8'h55);
        ct("dis_hi_inc", 8'h56);
        ct("dis_hi_once", 8'h56);

        taps = 4'b0000;
        wr(TAC_A, 8'h05);
        bus_set(1'b1, 1'b0, TAC_A, 8'h01); ct("dis_lo_wr", 8'h56);
        ct("dis_lo_none", 8'h56);
        ct("dis_lo_none2", 8'h56);

        wr(TAC_A, 8'h05);
        to_ovf();
        nreset = 1'b0;
        cti("rst_ovf", 8'h00, 1'b0);
        step();
        nreset = 1'b1;
        cti("rst_rel0", 8'h00, 1'b0);
        cti("rst_rel1", 8'h00, 1'b0);
        rd("rst2_tma", TMA_A, 8'h00);
        rd("rst2_tac", TAC_A, 8'hF8);
        rd("rst2_tima", TIMA_A, 8'h00);
        cti("rst_noint", 8'h00, 1'b0);

        repeat (2) step();
        final_chk = 1'b1;
        @(negedge clk); #1;
        final_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencer for the programmable timer: TIMA (FF05), TMA (FF06) and TAC (FF07).
- Selects one divider tap from the clocks/reset divider chain and detects its falling edges to increment TIMA.
- On TIMA overflow, runs the delayed TMA-reload sequence and raises the timer interrupt request.
- Sits beside the divider on the CPU data bus and shares its FF04–FF07 address decode.

Parameters:
- RELOAD_DELAY, 1: number of clk cycles TIMA reads 0x00 between overflow and reload (1..3).
- TAC_RD_MASK, 8'hF8: unimplemented TAC bits, forced to 1 on read.

Ports:
- clk  in  1  1 MHz machine-cycle clock (boga1mhz); all state updates on the rising edge.
- nreset  in  1  async active-low reset.
- ff04_ff07  in  1  address decode for FF04–FF07.
- tovy_na0  in  1  inverted address bit 0.
- tola_na1  in  1  inverted address bit 1.
- cpu_wr  in  1  CPU write strobe, sampled on the clk rising edge.
- cpu_rd  in  1  CPU read strobe.
- d  inout  8  CPU data bus, tristate.
- div_taps  in  4  divider taps, each synchronous to clk: [0]=4096 Hz, [1]=262144 Hz, [2]=65536 Hz, [3]=16384 Hz.
- int_timer  out  1  timer interrupt request: one-cycle registered pulse.
- tima_q  out  8  current TIMA value, for debug and the bench.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on port nreset.
- Reset values: TIMA=0x00, TMA=0x00, TAC=0x00 (reads 0xF8), int_timer=0, state=RUN, sel_q=0, delay count=0, d released (high-Z).
- Address decode: a[1:0] = {!tola_na1, !tovy_na0}.
  - a=0 is FF04, owned by the divider; this block ignores it.
  - a=1 TIMA, a=2 TMA, a=3 TAC.
- Reads: d driven combinationally while ff04_ff07 && cpu_rd && a!=0; otherwise high-Z.
  - TAC reads as {TAC_RD_MASK[7:3] ones, TAC[2:0]}.
  - TIMA reads its live value, including 0x00 during OVF.
- Writes: take effect at the rising edge where ff04_ff07 && cpu_wr && a!=0. Only TAC[2:0] is stored.
- Tick generation:
  - sel = TAC[2] && div_taps[TAC[1:0]]; sel_q <= sel each cycle; inc = sel_q && !sel.
  - Consequences that must be reproduced exactly:
    - Clearing TAC[2] while the selected tap is 1 produces one increment.
    - A TAC select change that moves sel from 1 to 0 produces one increment.
    - Divider reset via a FF04 write forces the taps low, so it increments if the selected tap was 1.
- States: RUN, OVF, RELOAD.
  - RUN:
    - Write to TIMA loads d, and wins over inc in the same cycle.
    - Otherwise inc with TIMA<0xFF gives TIMA+1.
    - inc with TIMA==0xFF gives TIMA=0x00, delay count=RELOAD_DELAY, state=OVF.
  - OVF:
    - inc still increments TIMA normally (8-bit wrap, no nested overflow).
    - A TIMA write loads d, cancels the reload and the interrupt, and returns to RUN.
    - Otherwise the count decrements. At count 1, on the next edge: TIMA<=TMA, int_timer<=1, state<=RELOAD.
  - RELOAD (exactly 1 cycle):
    - int_timer=1.
    - A TIMA write is ignored.
    - A TMA write updates TMA and also TIMA, with the same value, at the same edge.
    - inc is ignored.
    - Next edge: int_timer<=0, state<=RUN.
- TMA written in the same cycle the reload edge occurs: TIMA takes the new d value, not the old TMA.
- TAC writes are accepted in every state and do not disturb the reload sequence.
- nreset asserted mid-sequence: everything returns to reset values immediately; no interrupt pulse is emitted.
- int_timer never asserts for more than one cycle. Back-to-back overflows give separate pulses.

Decomposition:
- Shared package timer_pkg:
  - enum tstate_t {RUN, OVF, RELOAD}.
  - Register offsets TIMA_A=1, TMA_A=2, TAC_A=3.
  - TAC field positions (TAC_EN=2, TAC_SEL=1:0).
- One sub-module, timer_tick_sel: tap mux plus falling-edge detector producing inc.
  - Kept separate because the APU frame sequencer reuses it.
- Register file, bus tristate and state machine stay in timer_ctrl.

Test Plan:
- Reset, then read FF05/FF06/FF07 -> 0x00, 0x00, 0xF8; int_timer=0; d high-Z when cpu_rd=0.
- TAC=0x05 (enabled, 262144 Hz tap, toggling every 2 clk), TIMA=0xFE -> TIMA 0xFF after first tap fall, 0x00 after second. TIMA reads 0x00 for 1 cycle, then equals TMA (0x80). int_timer high exactly 1 cycle, coincident with the reload.
- Overflow, then TIMA write of 0x33 during the OVF cycle -> TIMA=0x33, no reload, int_timer stays 0.
- During the RELOAD cycle: TIMA write of 0x11 is ignored (TIMA=TMA); TMA write of 0x44 sets TMA=TIMA=0x44.
- Tap selected and high, TAC write 0x05->0x01 (disable) -> TIMA increments by exactly 1. Same tap low -> no change.
- nreset pulled low during OVF with TIMA=0x00 -> all registers 0, state RUN, no int_timer pulse after release.
